mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage RV32I pipeline, directly downstream of Execute.
- Consumes the ALU result, store data, func3, opcode and rd from Execute, and runs the data-memory request/acknowledge handshake for loads and stores.
- Formats load data (byte/half, sign/zero extension) and registers the result toward Writeback.
- Stalls Execute while a memory access is outstanding, and provides MEM-to-EX forwarding data.

Parameters:
- ADDR_WIDTH, 32: data-memory byte-address width; matches the global `ADDR_WIDTH.
- TIMEOUT, 16: maximum wait cycles for i_dmem_ack before a bus error is flagged; range 2..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_result  in  32  ALU result from Execute; the byte address for loads and stores.
- i_data_store  in  32  store data from Execute (rs2).
- i_func3  in  3  func3 from Execute.
- i_opcode  in  7  opcode from Execute.
- i_rd  in  5  destination register.
- i_ex_valid  in  1  Execute presents a valid instruction.
- o_stall  out  1  stall Execute; its inputs hold while high.
- o_dmem_req  out  1  data-memory request.
- o_dmem_we  out  1  1 = store, 0 = load.
- o_dmem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
- o_dmem_wdata  out  32  store data, lane-shifted.
- o_dmem_be  out  4  byte enables.
- i_dmem_ack  in  1  memory completes the access this cycle.
- i_dmem_rdata  in  32  read word; valid when i_dmem_ack is high.
- o_wb_valid  out  1  Writeback register holds an instruction.
- o_wb_en  out  1  register-file write enable.
- o_wb_rd  out  5  destination register.
- o_wb_data  out  32  writeback data.
- o_misaligned  out  1  misaligned load/store; 1-cycle pulse aligned with o_wb_valid.
- o_bus_err  out  1  ack timeout; 1-cycle pulse aligned with o_wb_valid.

Behaviour:
- Reset: every output is 0 and the FSM enters IDLE. Reset mid-access abandons the request: o_dmem_req drops on the next edge and no writeback occurs.
- FSM states:
  - IDLE: accepts an instruction when i_ex_valid is high.
  - WAIT: a request is outstanding.
- Accept in IDLE, non-memory opcode: on the next edge, o_wb_valid=1, o_wb_data=i_result, o_wb_rd=i_rd, and o_wb_en=(i_rd!=0) except for `B and `S, where o_wb_en=0. Latency is 1 cycle; the FSM stays in IDLE.
- Accept in IDLE, `L or `S, aligned: on the edge, register o_dmem_req=1, we, addr=i_result & ~3, be, wdata and the load-format fields; go to WAIT. o_wb_valid=0 that cycle.
- Alignment rules:
  - Byte accesses are always aligned.
  - Half accesses are misaligned when addr[0]=1.
  - Word accesses are misaligned when addr[1:0]!=0.
- Misaligned access: no request is issued. Next edge: o_wb_valid=1, o_wb_en=0, o_misaligned=1, and the FSM stays in IDLE.
- Store byte enables and data:
  - SB: be=4'b0001<<a, wdata=byte replicated x4.
  - SH: be=4'b0011<<a, wdata=half replicated x2.
  - SW: be=4'hF.
- Load extraction from rdata shifted right by 8*a:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word.
  - be=4'hF for all loads.
- o_stall = (state==WAIT). This is a Moore output with no combinational path from i_dmem_ack.
- WAIT with i_dmem_ack=1: on the edge, o_dmem_req=0 and state returns to IDLE. o_wb_valid=1, o_wb_rd=rd, o_wb_data=formatted load (store: i_result, o_wb_en=0). A load has o_wb_en=(rd!=0).
- Execute is not accepted in the ack cycle, giving one bubble. Minimum memory-op latency is 2 cycles.
- Address, data and enables are held stable while o_dmem_req=1.
- Timeout counter: cleared on entry to WAIT and incremented each WAIT cycle without ack. When it reaches TIMEOUT-1 with no ack, the next edge drops the request and returns to IDLE with o_wb_valid=1, o_wb_en=0, o_bus_err=1.
- An ack arriving in the same cycle the counter reaches TIMEOUT-1 takes priority over the timeout.
- o_wb_valid, o_misaligned and o_bus_err default to 0 in any cycle with no completion. i_ex_valid=0 in IDLE produces no writeback.
- A stray i_dmem_ack received in IDLE is ignored.

Decomposition:
- Shared defines package (existing): `N, `ADDR_WIDTH, opcode constants `L, `S, `B, and func3 encodings LB/LH/LW/LBU/LHU/SB/SH/SW.
- One sub-module: load_align (combinational). Inputs are rdata, byte offset and func3; output is the extended 32-bit value.
- The store lane/be logic stays inline.

Test Plan:
- ADD, rd=5, i_result=0x0000_1234 -> next cycle: o_wb_valid=1, o_wb_en=1, o_wb_rd=5, o_wb_data=0x1234, o_stall=0 throughout.
- LB, addr=0x103, rdata=0x80FF_FF7F, ack 3 cycles after req:
  - During access: o_dmem_addr=0x100, o_stall high for 3 cycles.
  - At completion: o_wb_data=0xFFFF_FF80.
  - Repeat with LBU: o_wb_data=0x0000_0080.
- SH, addr=0x22, store data=0x0000_BEEF, immediate ack -> be=4'b1100, wdata=0xBEEF_BEEF, we=1; then o_wb_valid=1, o_wb_en=0.
- LW, addr=0x6 -> no o_dmem_req; next cycle o_misaligned=1, o_wb_en=0; FSM remains in IDLE and accepts the next instruction.
- LW with ack never asserted (TIMEOUT=16) -> o_stall high for exactly 16 cycles, then o_bus_err=1 for 1 cycle, o_dmem_req=0; a following ADD completes normally.
- Assert rst during WAIT -> next edge: all outputs 0; a late ack is ignored; no writeback.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants and types for the RV32I memory stage.
//   - opcode constants (load, store, branch)
//   - func3 encodings for loads and stores
//   - FSM state type
//   - helper that decides alignment of an access from func3 and byte offset
package mem_stage_pkg;

    localparam int DEF_ADDR_WIDTH = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // func3[1:0] carries the access size for both loads and stores:
    // 00 byte, 01 half, 10 word. Bytes can never be misaligned.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/acknowledge bus.
//   o_dmem_req   request, held until ack or abandon
//   o_dmem_we    1 = store, 0 = load
//   o_dmem_addr  word-aligned byte address
//   o_dmem_wdata lane-shifted store data
//   o_dmem_be    byte enables
//   i_dmem_ack   memory completes the access this cycle
//   i_dmem_rdata read word, valid with i_dmem_ack
// Signal names are from the memory stage's point of view.
interface mem_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  o_dmem_req;
    logic                  o_dmem_we;
    logic [ADDR_WIDTH-1:0] o_dmem_addr;
    logic [31:0]           o_dmem_wdata;
    logic [3:0]            o_dmem_be;
    logic                  i_dmem_ack;
    logic [31:0]           i_dmem_rdata;

    modport master (
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
        input  i_dmem_ack, i_dmem_rdata
    );

    modport slave (
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
        output i_dmem_ack, i_dmem_rdata
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// mem_stage_load_align: combinational load formatter.
//   i_rdata  read word from memory
//   i_off    byte offset of the access within the word
//   i_func3  load type (LB/LH/LW/LBU/LHU)
//   o_data   lane-selected, sign/zero-extended result
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_func3,
    output logic [31:0] o_data
);
    logic [31:0] shifted;

    assign shifted = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_data = shifted;
        case (i_func3)
            F3_LB:   o_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   o_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  o_data = {24'd0, shifted[7:0]};
            F3_LHU:  o_data = {16'd0, shifted[15:0]};
            default: o_data = shifted;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage.
// Accepts one instruction from Execute when idle. Non-memory instructions
// complete in one cycle; aligned loads/stores issue a data-memory request and
// stall Execute until ack or timeout. Misaligned accesses never reach memory.
//   clk, rst           clock, synchronous active-high reset
//   i_result..i_rd     instruction fields from Execute
//   i_ex_valid         Execute presents a valid instruction
//   o_stall            hold Execute (Moore, high while a request is outstanding)
//   dmem               data-memory bus (master side)
//   o_wb_*             registered writeback result
//   o_misaligned       1-cycle pulse with o_wb_valid for a misaligned access
//   o_bus_err          1-cycle pulse with o_wb_valid for an ack timeout
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        i_result,
    input  logic [31:0]        i_data_store,
    input  logic [2:0]         i_func3,
    input  logic [6:0]         i_opcode,
    input  logic [4:0]         i_rd,
    input  logic               i_ex_valid,
    output logic               o_stall,
    mem_stage_if.master        dmem,
    output logic               o_wb_valid,
    output logic               o_wb_en,
    output logic [4:0]         o_wb_rd,
    output logic [31:0]        o_wb_data,
    output logic               o_misaligned,
    output logic               o_bus_err
);
    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [2:0]            func3_q, func3_d;
    logic [1:0]            off_q, off_d;
    logic [4:0]            rd_q, rd_d;
    logic [31:0]           result_q, result_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_en_q, wb_en_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic [31:0]           wb_data_q, wb_data_d;
    logic                  mis_q, mis_d;
    logic                  berr_q, berr_d;

    logic                  is_mem;
    logic                  mis_now;
    logic [31:0]           load_val;
    logic [3:0]            st_be;
    logic [31:0]           st_wdata;

    assign is_mem  = (i_opcode == OPC_LOAD) || (i_opcode == OPC_STORE);
    assign mis_now = is_misaligned(i_func3, i_result[1:0]);

    // Store lane steering: replicate the datum across the word so the byte
    // enables alone select the target lanes.
    always_comb begin
        st_be    = 4'hF;
        st_wdata = i_data_store;
        if (i_opcode == OPC_STORE) begin
            case (i_func3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << i_result[1:0];
                    st_wdata = {4{i_data_store[7:0]}};
                end
                2'b01: begin
                    st_be    = 4'b0011 << i_result[1:0];
                    st_wdata = {2{i_data_store[15:0]}};
                end
                default: begin
                    st_be    = 4'hF;
                    st_wdata = i_data_store;
                end
            endcase
        end
    end

    mem_stage_load_align u_load_align (
        .i_rdata (dmem.i_dmem_rdata),
        .i_off   (off_q),
        .i_func3 (func3_q),
        .o_data  (load_val)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        func3_d    = func3_q;
        off_d      = off_q;
        rd_d       = rd_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_en_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        mis_d      = 1'b0;
        berr_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_ex_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_en_d    = (i_rd != 5'd0) && (i_opcode != OPC_BRANCH);
                        wb_rd_d    = i_rd;
                        wb_data_d  = i_result;
                    end else if (mis_now) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = i_rd;
                        wb_data_d  = i_result;
                        mis_d      = 1'b1;
                    end else begin
                        req_d    = 1'b1;
                        we_d     = (i_opcode == OPC_STORE);
                        addr_d   = {i_result[ADDR_WIDTH-1:2], 2'b00};
                        wdata_d  = (i_opcode == OPC_STORE) ? st_wdata : 32'd0;
                        be_d     = st_be;
                        func3_d  = i_func3;
                        off_d    = i_result[1:0];
                        rd_d     = i_rd;
                        result_d = i_result;
                        cnt_d    = 8'd0;
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Ack wins over a timeout landing in the same cycle.
                if (dmem.i_dmem_ack) begin
                    req_d      = 1'b0;
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    if (we_q) begin
                        wb_data_d = result_q;
                        wb_en_d   = 1'b0;
                    end else begin
                        wb_data_d = load_val;
                        wb_en_d   = (rd_q != 5'd0);
                    end
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    req_d      = 1'b0;
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    berr_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            func3_q    <= 3'd0;
            off_q      <= 2'd0;
            rd_q       <= 5'd0;
            result_q   <= 32'd0;
            cnt_q      <= 8'd0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            func3_q    <= func3_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_en_q    <= wb_en_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            mis_q      <= mis_d;
            berr_q     <= berr_d;
        end
    end

    assign o_stall           = (state_q == S_WAIT);
    assign dmem.o_dmem_req   = req_q;
    assign dmem.o_dmem_we    = we_q;
    assign dmem.o_dmem_addr  = addr_q;
    assign dmem.o_dmem_wdata = wdata_q;
    assign dmem.o_dmem_be    = be_q;
    assign o_wb_valid        = wb_valid_q;
    assign o_wb_en           = wb_en_q;
    assign o_wb_rd           = wb_rd_q;
    assign o_wb_data         = wb_data_q;
    assign o_misaligned      = mis_q;
    assign o_bus_err         = berr_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with hand-computed expectations.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam logic [6:0] OPC_OP = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_result, i_data_store;
    logic [2:0]  i_func3;
    logic [6:0]  i_opcode;
    logic [4:0]  i_rd;
    logic        i_ex_valid;
    logic        o_stall, o_wb_valid, o_wb_en, o_misaligned, o_bus_err;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;

    int checks = 0;
    int errors = 0;
    int stalls;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we, cap_req;

    mem_stage_if #(.ADDR_WIDTH(32)) dmem ();

    mem_stage #(.ADDR_WIDTH(32), .TIMEOUT(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_result     (i_result),
        .i_data_store (i_data_store),
        .i_func3      (i_func3),
        .i_opcode     (i_opcode),
        .i_rd         (i_rd),
        .i_ex_valid   (i_ex_valid),
        .o_stall      (o_stall),
        .dmem         (dmem),
        .o_wb_valid   (o_wb_valid),
        .o_wb_en      (o_wb_en),
        .o_wb_rd      (o_wb_rd),
        .o_wb_data    (o_wb_data),
        .o_misaligned (o_misaligned),
        .o_bus_err    (o_bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] res, input logic [31:0] sd);
        i_ex_valid   = v;
        i_opcode     = opc;
        i_func3      = f3;
        i_rd         = rd;
        i_result     = res;
        i_data_store = sd;
    endtask

    // Accept edge, then n_wait stalled cycles with ack raised in the last one.
    // Execute keeps presenting the instruction while stalled.
    task automatic run_mem(input int n_wait, input logic [31:0] rdata, output int n_stall);
        n_stall = 0;
        step();
        cap_req   = dmem.o_dmem_req;
        cap_we    = dmem.o_dmem_we;
        cap_addr  = dmem.o_dmem_addr;
        cap_be    = dmem.o_dmem_be;
        cap_wdata = dmem.o_dmem_wdata;
        for (int k = 1; k <= n_wait; k++) begin
            if (o_stall) n_stall++;
            if (k == n_wait) begin
                chk("held_addr", dmem.o_dmem_addr, cap_addr);
                dmem.i_dmem_ack   = 1'b1;
                dmem.i_dmem_rdata = rdata;
                i_ex_valid        = 1'b0;
            end
            step();
        end
        dmem.i_dmem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0);
        dmem.i_dmem_ack   = 1'b0;
        dmem.i_dmem_rdata = 32'd0;
        step();
        step();
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_req", 32'(dmem.o_dmem_req), 32'd0);
        chk("rst_wb_valid", 32'(o_wb_valid), 32'd0);
        chk("rst_wb_data", o_wb_data, 32'd0);
        chk("rst_flags", 32'({o_misaligned, o_bus_err, o_wb_en}), 32'd0);
        rst = 1'b0;

        // ADD rd=5
        drive(1'b1, OPC_OP, 3'd0, 5'd5, 32'h0000_1234, 32'd0);
        step();
        chk("add_valid", 32'(o_wb_valid), 32'd1);
        chk("add_en", 32'(o_wb_en), 32'd1);
        chk("add_rd", 32'(o_wb_rd), 32'd5);
        chk("add_data", o_wb_data, 32'h0000_1234);
        chk("add_stall", 32'(o_stall), 32'd0);
        i_ex_valid = 1'b0;
        step();
        chk("idle_no_wb", 32'(o_wb_valid), 32'd0);

        // Branch: writes nothing even with rd!=0
        drive(1'b1, OPC_BRANCH, 3'd0, 5'd9, 32'h44, 32'd0);
        step();
        chk("br_valid_en", 32'({o_wb_valid, o_wb_en}), 32'b10);

        // LB 0x103, ack in third stalled cycle
        drive(1'b1, OPC_LOAD, F3_LB, 5'd7, 32'h0000_0103, 32'd0);
        run_mem(3, 32'h80FF_FF7F, stalls);
        chk("lb_req", 32'(cap_req), 32'd1);
        chk("lb_addr", cap_addr, 32'h0000_0100);
        chk("lb_we_be", 32'({cap_we, cap_be}), 32'h0F);
        chk("lb_stalls", 32'(stalls), 32'd3);
        chk("lb_done", 32'({o_stall, dmem.o_dmem_req, o_wb_valid, o_wb_en}), 32'b0011);
        chk("lb_rd", 32'(o_wb_rd), 32'd7);
        chk("lb_data", o_wb_data, 32'hFFFF_FF80);

        drive(1'b1, OPC_LOAD, F3_LBU, 5'd7, 32'h0000_0103, 32'd0);
        run_mem(3, 32'h80FF_FF7F, stalls);
        chk("lbu_data", o_wb_data, 32'h0000_0080);

        // LH upper half, sign-extended
        drive(1'b1, OPC_LOAD, F3_LH, 5'd3, 32'h0000_0102, 32'd0);
        run_mem(2, 32'h80FF_FF7F, stalls);
        chk("lh_data", o_wb_data, 32'hFFFF_80FF);

        // LHU into x0: data formatted but no write
        drive(1'b1, OPC_LOAD, F3_LHU, 5'd0, 32'h0000_0102, 32'd0);
        run_mem(1, 32'h80FF_FF7F, stalls);
        chk("lhu_data", o_wb_data, 32'h0000_80FF);
        chk("lhu_x0_en", 32'({o_wb_valid, o_wb_en}), 32'b10);

        // SH 0x22, immediate ack
        drive(1'b1, OPC_STORE, F3_SH, 5'd0, 32'h0000_0022, 32'h0000_BEEF);
        run_mem(1, 32'd0, stalls);
        chk("sh_addr", cap_addr, 32'h0000_0020);
        chk("sh_be", 32'(cap_be), 32'hC);
        chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        chk("sh_we", 32'(cap_we), 32'd1);
        chk("sh_stalls", 32'(stalls), 32'd1);
        chk("sh_done", 32'({o_wb_valid, o_wb_en}), 32'b10);

        // SB 0x41
        drive(1'b1, OPC_STORE, F3_SB, 5'd0, 32'h0000_0041, 32'h0000_00A5);
        run_mem(1, 32'd0, stalls);
        chk("sb_be", 32'(cap_be), 32'h2);
        chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);

        // LW 0x6 misaligned, then ADD straight after
        drive(1'b1, OPC_LOAD, F3_LW, 5'd4, 32'h0000_0006, 32'd0);
        step();
        chk("mis_req", 32'(dmem.o_dmem_req), 32'd0);
        chk("mis_flags", 32'({o_wb_valid, o_wb_en, o_misaligned, o_stall}), 32'b1010);
        drive(1'b1, OPC_OP, 3'd0, 5'd6, 32'h0000_0055, 32'd0);
        step();
        chk("mis_next", 32'({o_wb_valid, o_wb_en, o_misaligned}), 32'b110);
        chk("mis_next_data", o_wb_data, 32'h0000_0055);

        // Ack in the last cycle before timeout still completes normally
        drive(1'b1, OPC_LOAD, F3_LW, 5'd8, 32'h0000_0040, 32'd0);
        run_mem(16, 32'h1234_5678, stalls);
        chk("edge_berr", 32'(o_bus_err), 32'd0);
        chk("edge_data", o_wb_data, 32'h1234_5678);

        // LW with no ack: 16 stalled cycles then bus error
        drive(1'b1, OPC_LOAD, F3_LW, 5'd8, 32'h0000_0080, 32'd0);
        step();
        stalls = 0;
        while (o_stall && stalls < 40) begin
            stalls++;
            if (stalls == 1) i_ex_valid = 1'b0;
            step();
        end
        chk("to_stalls", 32'(stalls), 32'd16);
        chk("to_flags", 32'({o_bus_err, o_wb_valid, o_wb_en, dmem.o_dmem_req}), 32'b1100);
        drive(1'b1, OPC_OP, 3'd0, 5'd2, 32'h0000_0077, 32'd0);
        step();
        chk("to_next", 32'({o_bus_err, o_wb_valid, o_wb_en}), 32'b011);
        chk("to_next_data", o_wb_data, 32'h0000_0077);

        // Reset during WAIT, then a late ack
        drive(1'b1, OPC_LOAD, F3_LW, 5'd9, 32'h0000_0200, 32'd0);
        step();
        i_ex_valid = 1'b0;
        step();
        chk("rw_stall", 32'(o_stall), 32'd1);
        rst = 1'b1;
        step();
        chk("rw_out", 32'({o_stall, dmem.o_dmem_req, o_wb_valid, o_wb_en}), 32'd0);
        chk("rw_addr", dmem.o_dmem_addr, 32'd0);
        rst = 1'b0;
        dmem.i_dmem_ack   = 1'b1;
        dmem.i_dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem.i_dmem_ack = 1'b0;
        chk("late_ack", 32'({o_stall, dmem.o_dmem_req, o_wb_valid}), 32'd0);
        chk("late_ack_data", o_wb_data, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
